// File: rtl/snax_hwpe_ctrl_pkg.sv
// Shared types and CSR decode for the buffered SNAX-to-HWPE control bridge.
// Request FIFO entries are stored already decoded as hwpe_ctrl_req_t.
package snax_hwpe_ctrl_pkg;

    localparam int unsigned PeriphWidth = 32;
    localparam int unsigned IdWidth     = 5;
    localparam logic [6:0]  OpcSystem   = 7'b1110011;

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic [PeriphWidth-1:0] add;
        logic                   wen;
        logic [3:0]             be;
        logic [PeriphWidth-1:0] data;
        logic                   err;
    } hwpe_ctrl_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic                   error;
        logic [PeriphWidth-1:0] data;
    } hwpe_ctrl_rsp_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [31:0]        data_op;
        logic [63:0]        data_arga;
        logic [63:0]        data_argb;
    } acc_req_dflt_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               error;
        logic [63:0]        data;
    } acc_rsp_dflt_t;

    typedef enum logic {StIdle, StIssue} issue_state_e;

    // funct3 values 001/010/011/101/110/111 are the six Zicsr ops; bit 1 set marks the read-modify ones
    function automatic hwpe_ctrl_req_t csr_decode(
        input logic [IdWidth-1:0] id,
        input logic [6:0]         opcode,
        input logic [2:0]         funct3,
        input logic [31:0]        arga,
        input logic [31:0]        argb,
        input logic [31:0]        csr_base,
        input logic [31:0]        num_regs
    );
        hwpe_ctrl_req_t r;
        logic           is_csr;
        logic           is_read;
        logic [31:0]    off;
        is_csr  = (opcode == OpcSystem) && (funct3[1:0] != 2'b00);
        is_read = is_csr && funct3[1];
        off     = arga - csr_base;
        r.id    = id;
        r.add   = is_csr ? (off << 2) : arga;
        r.wen   = is_read;
        r.be    = is_read ? 4'h0 : 4'hF;
        r.data  = argb;
        r.err   = is_csr && (off >= num_regs);
        return r;
    endfunction

endpackage

// File: rtl/snax_hwpe_ctrl_fifo.sv
// Generic register FIFO with a type parameter and occupancy count output.
// Latency 1 cycle push-to-head; pushes while full without a pop are dropped.
module snax_hwpe_ctrl_fifo #(
    parameter type         T     = logic [31:0],
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    output T                             data_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);

    T                mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            empty, full, pass, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(Depth));
    // push and pop on an empty FIFO hands the word straight through
    assign pass    = empty & push_i & pop_i;
    assign do_push = push_i & (~full | pop_i) & ~pass;
    assign do_pop  = pop_i & ~empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    assign data_o  = empty ? data_i : mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/snax_hwpe_buff_ctrl.sv
// Buffered SNAX accelerator stream to HWPE control-port bridge; optional SNAX_HWPE_CTRL_ERR_EN range check.
// Latency >= 1 cycle request to periph; reads credit-limited by response FIFO depth.
module snax_hwpe_buff_ctrl
    import snax_hwpe_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ReqDepth  = 4,
    parameter int unsigned RspDepth  = 4,
    parameter int unsigned CsrBase   = 960,
    parameter int unsigned NumRegs   = 32,
    parameter type         acc_req_t = acc_req_dflt_t,
    parameter type         acc_rsp_t = acc_rsp_dflt_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  acc_req_t    req_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output acc_rsp_t    resp_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        periph_req_o,
    input  logic        periph_gnt_i,
    output logic [31:0] periph_add_o,
    output logic        periph_wen_o,
    output logic [3:0]  periph_be_o,
    output logic [31:0] periph_data_o,
    output logic [4:0]  periph_id_o,
    input  logic        periph_r_valid_i,
    input  logic [31:0] periph_r_data_i,
    input  logic [4:0]  periph_r_id_i
);

    localparam int unsigned ReqCntW = $clog2(ReqDepth+1);
    localparam int unsigned RspCntW = $clog2(RspDepth+1);

    hwpe_ctrl_req_t     req_dec, req_head, iss_q, iss_d;
    logic [ReqCntW-1:0] req_cnt;
    logic               req_empty, req_push, req_pop;
    acc_rsp_t           rsp_in;
    logic [RspCntW-1:0] rsp_cnt;
    logic               rsp_push, rsp_pop;
    issue_state_e       state_q, state_d;
    logic [RspCntW-1:0] outst_q, outst_d;
    logic [RspCntW:0]   inflight;
    logic               head_err, credit_ok, head_ok, err_push, rd_gnt, r_acc;
    logic               unused_bits;

    assign req_empty   = (req_cnt == '0);
    assign req_ready_o = (req_cnt != ReqCntW'(ReqDepth));
    assign req_push    = req_valid_i & req_ready_o;

    assign req_dec = csr_decode(req_i.id, req_i.data_op[6:0], req_i.data_op[14:12],
                                req_i.data_arga[31:0], req_i.data_argb[31:0],
                                32'(CsrBase), 32'(NumRegs));

    snax_hwpe_ctrl_fifo #(
        .T     (hwpe_ctrl_req_t),
        .Depth (ReqDepth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_push),
        .data_i  (req_dec),
        .pop_i   (req_pop),
        .data_o  (req_head),
        .count_o (req_cnt)
    );

`ifdef SNAX_HWPE_CTRL_ERR_EN
    assign head_err = req_head.err;
`else
    assign head_err = 1'b0;
`endif

    // a read sitting in the issue register already owns a credit even before its grant
    assign inflight  = {1'b0, outst_q} + {1'b0, rsp_cnt}
                     + (RspCntW+1)'((state_q == StIssue) && iss_q.wen);
    assign credit_ok = inflight < (RspCntW+1)'(RspDepth);
    assign head_ok   = ~req_empty & ~head_err & (~req_head.wen | credit_ok);

    always_comb begin
        state_d  = state_q;
        iss_d    = iss_q;
        req_pop  = 1'b0;
        err_push = 1'b0;
        case (state_q)
            StIdle: begin
                if (~req_empty && head_err) begin
                    // out-of-range reads answer locally; they must not collide with a periph response push
                    if (~req_head.wen) begin
                        req_pop = 1'b1;
                    end else if (credit_ok && ~periph_r_valid_i) begin
                        req_pop  = 1'b1;
                        err_push = 1'b1;
                    end
                end else if (head_ok) begin
                    req_pop = 1'b1;
                    iss_d   = req_head;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (periph_gnt_i) begin
                    if (head_ok) begin
                        req_pop = 1'b1;
                        iss_d   = req_head;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_gnt = (state_q == StIssue) & periph_gnt_i & iss_q.wen;
    assign r_acc  = periph_r_valid_i & (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        case ({rd_gnt, r_acc})
            2'b10:   outst_d = outst_q + RspCntW'(1);
            2'b01:   outst_d = outst_q - RspCntW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            iss_q   <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            outst_q <= outst_d;
        end
    end

    always_comb begin
        rsp_in       = '0;
        rsp_in.id    = periph_r_id_i;
        rsp_in.error = 1'b0;
        rsp_in.data  = DataWidth'(periph_r_data_i);
        if (err_push) begin
            rsp_in.id    = req_head.id;
            rsp_in.error = 1'b1;
            rsp_in.data  = '0;
        end
    end

    assign rsp_push     = r_acc | err_push;
    assign resp_valid_o = (rsp_cnt != '0);
    assign rsp_pop      = resp_valid_o & resp_ready_i;

    snax_hwpe_ctrl_fifo #(
        .T     (acc_rsp_t),
        .Depth (RspDepth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rsp_push),
        .data_i  (rsp_in),
        .pop_i   (rsp_pop),
        .data_o  (resp_o),
        .count_o (rsp_cnt)
    );

    assign periph_req_o  = (state_q == StIssue);
    assign periph_add_o  = iss_q.add;
    assign periph_wen_o  = iss_q.wen;
    assign periph_be_o   = iss_q.be;
    assign periph_data_o = iss_q.data;
    assign periph_id_o   = iss_q.id;

    assign unused_bits = ^{req_i, iss_q};

    a_rvalid_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) periph_r_valid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_snax_hwpe_buff_ctrl.sv
// Directed bench for snax_hwpe_buff_ctrl with a peripheral model answering reads 2 cycles after grant.
// Read data returned is (byte address / 4) + 1, so CSR 960+k reads back k+1.
module tb_snax_hwpe_buff_ctrl;
    import snax_hwpe_ctrl_pkg::*;

    localparam logic [31:0] OpCsrrw = 32'h0000_1073;
    localparam logic [31:0] OpCsrrs = 32'h0000_2073;

    logic          clk = 1'b0;
    logic          rst;
    acc_req_dflt_t req;
    logic          req_valid, req_ready;
    acc_rsp_dflt_t resp;
    logic          resp_valid, resp_ready;
    logic          periph_req, periph_gnt, periph_wen;
    logic [31:0]   periph_add, periph_data;
    logic [3:0]    periph_be;
    logic [4:0]    periph_id;
    logic          r_valid;
    logic [31:0]   r_data;
    logic [4:0]    r_id;

    int errors = 0;
    int checks = 0;

    typedef struct {int due; logic [31:0] d; logic [4:0] id;} pend_t;
    typedef struct {logic [31:0] add; logic [31:0] data; logic [3:0] be;} wr_t;
    pend_t         pend_q[$];
    wr_t           wr_q[$];
    acc_rsp_dflt_t rsp_q[$];
    int            cyc = 0;
    int            grants = 0;
    int            first_g = 0;
    int            last_g = 0;
    logic [31:0]   last_add = '0;

    always #5 clk = ~clk;

    snax_hwpe_buff_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .periph_req_o     (periph_req),
        .periph_gnt_i     (periph_gnt),
        .periph_add_o     (periph_add),
        .periph_wen_o     (periph_wen),
        .periph_be_o      (periph_be),
        .periph_data_o    (periph_data),
        .periph_id_o      (periph_id),
        .periph_r_valid_i (r_valid),
        .periph_r_data_i  (r_data),
        .periph_r_id_i    (r_id)
    );

    // peripheral model: acts 2ns after each falling edge so the main process has already driven gnt
    initial begin
        pend_t p;
        wr_t   w;
        r_valid = 1'b0;
        r_data  = '0;
        r_id    = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            r_valid = 1'b0;
            if (rst) begin
                pend_q.delete();
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    p       = pend_q.pop_front();
                    r_valid = 1'b1;
                    r_data  = p.d;
                    r_id    = p.id;
                end
                if (periph_req && periph_gnt) begin
                    if (grants == 0) first_g = cyc;
                    last_g   = cyc;
                    last_add = periph_add;
                    grants++;
                    if (periph_wen) begin
                        p.due = cyc + 2;
                        p.d   = (periph_add >> 2) + 32'd1;
                        p.id  = periph_id;
                        pend_q.push_back(p);
                    end else begin
                        w.add  = periph_add;
                        w.data = periph_data;
                        w.be   = periph_be;
                        wr_q.push_back(w);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] op, input logic [31:0] arga,
                        input logic [31:0] argb, input logic [4:0] id);
        int t = 0;
        req.id        = id;
        req.data_op   = op;
        req.data_arga = 64'(arga);
        req.data_argb = 64'(argb);
        req_valid     = 1'b1;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL send_timeout: req_ready stayed %b, expected 1 within 50 cycles", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic collect(input int n);
        int t = 0;
        rsp_q.delete();
        resp_ready = 1'b1;
        while (rsp_q.size() < n && t < 200) begin
            if (resp_valid) rsp_q.push_back(resp);
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req_valid = 1'b0; resp_ready = 1'b0; periph_gnt = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (periph_req !== 1'b0) begin errors++; $display("FAIL reset_periph_req: got %b expected 0", periph_req); end
        checks++; if ({periph_add, periph_wen, periph_be, periph_data, periph_id} !== 74'd0) begin
            errors++; $display("FAIL reset_periph_bus: got add=%h wen=%b be=%h data=%h id=%h expected all 0",
                               periph_add, periph_wen, periph_be, periph_data, periph_id); end
    endtask

    task automatic test_single_write;
        periph_gnt = 1'b0; grants = 0; wr_q.delete();
        send(OpCsrrw, 32'd962, 32'hDEAD_BEEF, 5'd3);
        req_valid = 1'b0;
        tick(1);
        checks++; if (periph_req !== 1'b1) begin errors++; $display("FAIL wr_req: got %b expected 1", periph_req); end
        checks++; if (periph_add !== 32'd8) begin errors++; $display("FAIL wr_add: got %h expected 8", periph_add); end
        checks++; if ({periph_wen, periph_be} !== 5'b0_1111) begin errors++; $display("FAIL wr_wen_be: got wen=%b be=%h expected wen=0 be=f", periph_wen, periph_be); end
        checks++; if (periph_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data: got %h expected deadbeef", periph_data); end
        checks++; if (periph_id !== 5'd3) begin errors++; $display("FAIL wr_id: got %0d expected 3", periph_id); end
        tick(1);
        checks++; if ({periph_req, periph_add, periph_data} !== {1'b1, 32'd8, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wr_hold: got req=%b add=%h data=%h expected 1/8/deadbeef", periph_req, periph_add, periph_data); end
        periph_gnt = 1'b1;
        tick(1);
        periph_gnt = 1'b0;
        checks++; if (periph_req !== 1'b0) begin errors++; $display("FAIL wr_drop_req: got %b expected 0", periph_req); end
        checks++; if (grants !== 1) begin errors++; $display("FAIL wr_grants: got %0d expected 1", grants); end
        tick(5);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_resp: got %b expected 0", resp_valid); end
    endtask

    task automatic test_raw_write;
        periph_gnt = 1'b1; wr_q.delete();
        send(32'h0000_0033, 32'h0000_1234, 32'hCAFE_0001, 5'd7);
        req_valid = 1'b0;
        tick(4);
        periph_gnt = 1'b0;
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL raw_count: got %0d expected 1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            checks++; if (wr_q[0].add !== 32'h0000_1234) begin errors++; $display("FAIL raw_add: got %h expected 1234", wr_q[0].add); end
            checks++; if ({wr_q[0].data, wr_q[0].be} !== {32'hCAFE_0001, 4'hF}) begin
                errors++; $display("FAIL raw_data_be: got %h/%h expected cafe0001/f", wr_q[0].data, wr_q[0].be); end
        end
    endtask

    task automatic test_back_to_back;
        periph_gnt = 1'b1; resp_ready = 1'b0; grants = 0;
        for (int k = 0; k < 4; k++) send(OpCsrrs, 32'(960 + k), 32'd0, 5'(10 + k));
        req_valid = 1'b0;
        tick(8);
        periph_gnt = 1'b0;
        checks++; if (grants !== 4) begin errors++; $display("FAIL b2b_grants: got %0d expected 4", grants); end
        checks++; if (last_g - first_g !== 3) begin errors++; $display("FAIL b2b_consecutive: got span %0d expected 3", last_g - first_g); end
        collect(4);
        checks++; if (rsp_q.size() !== 4) begin errors++; $display("FAIL b2b_rsp_count: got %0d expected 4", rsp_q.size()); end
        for (int k = 0; k < rsp_q.size(); k++) begin
            checks++; if (rsp_q[k].data !== 64'(k + 1)) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, rsp_q[k].data, 64'(k + 1)); end
            checks++; if ({rsp_q[k].id, rsp_q[k].error} !== {5'(10 + k), 1'b0}) begin
                errors++; $display("FAIL b2b_id%0d: got id=%0d err=%b expected id=%0d err=0", k, rsp_q[k].id, rsp_q[k].error, 10 + k); end
        end
    endtask

    task automatic test_credit_stall;
        periph_gnt = 1'b1; resp_ready = 1'b0; grants = 0;
        for (int k = 0; k < 6; k++) send(OpCsrrs, 32'(960 + k), 32'd0, 5'(k));
        req_valid = 1'b0;
        tick(10);
        checks++; if (grants !== 4) begin errors++; $display("FAIL credit_grants: got %0d expected 4", grants); end
        checks++; if (periph_req !== 1'b0) begin errors++; $display("FAIL credit_req_low: got %b expected 0", periph_req); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL credit_resp_valid: got %b expected 1", resp_valid); end
        collect(6);
        checks++; if (rsp_q.size() !== 6) begin errors++; $display("FAIL credit_rsp_count: got %0d expected 6", rsp_q.size()); end
        for (int k = 0; k < rsp_q.size(); k++) begin
            checks++; if ({rsp_q[k].id, rsp_q[k].data} !== {5'(k), 64'(k + 1)}) begin
                errors++; $display("FAIL credit_rsp%0d: got id=%0d data=%h expected id=%0d data=%h", k, rsp_q[k].id, rsp_q[k].data, k, 64'(k + 1)); end
        end
        checks++; if (grants !== 6) begin errors++; $display("FAIL credit_release: got %0d grants expected 6", grants); end
        periph_gnt = 1'b0;
    endtask

    task automatic test_req_full;
        periph_gnt = 1'b0; resp_ready = 1'b1; wr_q.delete();
        for (int k = 0; k < 5; k++) send(OpCsrrw, 32'(960 + k), 32'(100 + k), 5'(k));
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", req_ready); end
        checks++; if ({periph_req, periph_data} !== {1'b1, 32'd100}) begin
            errors++; $display("FAIL full_issue_reg: got req=%b data=%0d expected 1/100", periph_req, periph_data); end
        periph_gnt = 1'b1;
        tick(10);
        periph_gnt = 1'b0;
        checks++; if (wr_q.size() !== 5) begin errors++; $display("FAIL full_count: got %0d expected 5", wr_q.size()); end
        for (int k = 0; k < wr_q.size(); k++) begin
            checks++; if ({wr_q[k].add, wr_q[k].data} !== {32'(4 * k), 32'(100 + k)}) begin
                errors++; $display("FAIL full_wr%0d: got add=%h data=%0d expected add=%h data=%0d", k, wr_q[k].add, wr_q[k].data, 4 * k, 100 + k); end
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_drain_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_reset_mid;
        int t = 0;
        periph_gnt = 1'b1; resp_ready = 1'b0; grants = 0;
        send(OpCsrrs, 32'd960, 32'd0, 5'd1);
        send(OpCsrrs, 32'd961, 32'd0, 5'd2);
        req_valid = 1'b0;
        while (grants < 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++; if (grants !== 2) begin errors++; $display("FAIL rstmid_grants: got %0d expected 2", grants); end
        periph_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if ({periph_req, resp_valid, req_ready} !== 3'b001) begin
            errors++; $display("FAIL rstmid_async: got req=%b rvld=%b rdy=%b expected 0/0/1", periph_req, resp_valid, req_ready); end
        checks++; if ({periph_add, periph_wen, periph_be, periph_data, periph_id} !== 74'd0) begin
            errors++; $display("FAIL rstmid_bus: got add=%h wen=%b expected all 0", periph_add, periph_wen); end
        tick(1);
        rst = 1'b0;
        tick(6);
        checks++; if ({periph_req, resp_valid, req_ready} !== 3'b001) begin
            errors++; $display("FAIL rstmid_after: got req=%b rvld=%b rdy=%b expected 0/0/1", periph_req, resp_valid, req_ready); end
    endtask

    task automatic test_range;
        periph_gnt = 1'b1; resp_ready = 1'b0; grants = 0;
        send(OpCsrrs, 32'd1000, 32'd0, 5'd9);
        req_valid = 1'b0;
        tick(8);
        periph_gnt = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL range_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp.id !== 5'd9) begin errors++; $display("FAIL range_id: got %0d expected 9", resp.id); end
`ifdef SNAX_HWPE_CTRL_ERR_EN
        checks++; if (grants !== 0) begin errors++; $display("FAIL range_no_issue: got %0d grants expected 0", grants); end
        checks++; if ({resp.error, resp.data} !== {1'b1, 64'd0}) begin
            errors++; $display("FAIL range_err_rsp: got err=%b data=%h expected 1/0", resp.error, resp.data); end
`else
        checks++; if ({grants, last_add} !== {32'd1, 32'd160}) begin
            errors++; $display("FAIL range_forward: got grants=%0d add=%0d expected 1/160", grants, last_add); end
        checks++; if ({resp.error, resp.data} !== {1'b0, 64'd41}) begin
            errors++; $display("FAIL range_rsp: got err=%b data=%h expected 0/29", resp.error, resp.data); end
`endif
        collect(1);
        tick(2);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL range_drain: got %b expected 0", resp_valid); end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_raw_write;
        test_back_to_back;
        test_credit_stall;
        test_req_full;
        test_reset_mid;
        test_range;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
